seg7_scroll_ctrl: RTL and testbench

SEG7_SCROLL_CTRL -- requirements
Module: seg7_scroll_ctrl

---
 rtl/seg7_scroll_ctrl_if.sv | 24 ++
 rtl/seg7_scroll_ctrl.sv | 137 +++++++++++++
 tb/tb_seg7_scroll_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scroll_ctrl_if.sv
// Load/effect bundle between a display client and seg7_scroll_ctrl.
// The client drives data, mode and blank mask; the controller returns ack, tick and segments.
`timescale 1ns/1ps
interface seg7_scroll_ctrl_if #(
   parameter int NUM_DIG = 8
);
   logic                   iLOAD;
   logic [4*NUM_DIG-1:0]   iDATA;
   logic [1:0]             iMODE;
   logic [NUM_DIG-1:0]     iBLANK;
   logic                   oACK;
   logic                   oTICK;
   logic [7*NUM_DIG-1:0]   oSEG;

   modport master (
      output iLOAD, iDATA, iMODE, iBLANK,
      input  oACK, oTICK, oSEG
   );

   modport slave (
      input  iLOAD, iDATA, iMODE, iBLANK,
      output oACK, oTICK, oSEG
   );
endinterface

// File: rtl/seg7_scroll_ctrl.sv
// Multi-digit 7-segment controller with static, scroll, blink and count
// effects stepped by a prescaled tick; segment outputs are active-low.
`timescale 1ns/1ps
module seg7_scroll_ctrl #(
   parameter int NUM_DIG  = 8,
   parameter int TICK_DIV = 12500000
) (
   input logic              iCLK,
   input logic              iRST_N,
   seg7_scroll_ctrl_if.slave bus
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
   localparam int BW = 4 * NUM_DIG;
   localparam int SW = 7 * NUM_DIG;

   typedef enum logic [1:0] {
      M_STATIC = 2'b00,
      M_SCROLL = 2'b01,
      M_BLINK  = 2'b10,
      M_COUNT  = 2'b11
   } mode_e;

   mode_e          mode;
   mode_e          mode_q;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_n;
   logic [BW-1:0]  buffer;
   logic [BW-1:0]  buf_n;
   logic           phase;
   logic           phase_n;
   logic           tick;
   logic           ack_q;
   logic           tick_q;
   logic [SW-1:0]  seg_q;
   logic [SW-1:0]  seg_n;
   logic           mode_chg;
   logic           dark;

   assign mode     = mode_e'(bus.iMODE);
   assign tick     = (cnt == LAST);
   assign mode_chg = (mode != mode_q);
   assign dark     = (mode == M_BLINK) && !phase;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Digit k takes digit k-1; digit 0 wraps from the top digit.
   function automatic logic [BW-1:0] rotate(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      r = '0;
      for (int k = 0; k < NUM_DIG; k++) begin
         r[4*k +: 4] = v[4*((k + NUM_DIG - 1) % NUM_DIG) +: 4];
      end
      return r;
   endfunction

   always_comb begin
      cnt_n   = tick ? '0 : cnt + 1'b1;
      buf_n   = buffer;
      phase_n = phase;
      if (mode_chg) begin
         phase_n = 1'b1;
      end
      if (tick) begin
         unique case (mode)
            M_SCROLL: buf_n = rotate(buffer);
            M_BLINK:  phase_n = mode_chg ? 1'b1 : ~phase;
            M_COUNT:  buf_n = buffer + 1'b1;
            default:  buf_n = buffer;
         endcase
      end
      // A load overrides any tick effect on the same edge.
      if (bus.iLOAD) begin
         cnt_n   = '0;
         buf_n   = bus.iDATA;
         phase_n = 1'b1;
      end
   end

   always_comb begin
      seg_n = '1;
      for (int k = 0; k < NUM_DIG; k++) begin
         if (bus.iBLANK[k] || dark) begin
            seg_n[7*k +: 7] = 7'h7F;
         end else begin
            seg_n[7*k +: 7] = hex7(buffer[4*k +: 4]);
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         cnt    <= '0;
         buffer <= '0;
         phase  <= 1'b1;
         mode_q <= M_STATIC;
         ack_q  <= 1'b0;
         tick_q <= 1'b0;
         seg_q  <= '1;
      end else begin
         cnt    <= cnt_n;
         buffer <= buf_n;
         phase  <= phase_n;
         mode_q <= mode;
         ack_q  <= bus.iLOAD;
         tick_q <= tick;
         seg_q  <= seg_n;
      end
   end

   assign bus.oACK  = ack_q;
   assign bus.oTICK = tick_q;
   assign bus.oSEG  = seg_q;

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Directed bench for seg7_scroll_ctrl: decode table plus scroll, count,
// blink, load-on-tick, mode-change and mid-period reset sequences.
`timescale 1ns/1ps
module tb_seg7_scroll_ctrl;

   logic iCLK = 1'b0;
   logic iRST_N = 1'b0;

   seg7_scroll_ctrl_if #(.NUM_DIG(8)) bus ();

   seg7_scroll_ctrl #(
      .NUM_DIG  (8),
      .TICK_DIV (4)
   ) dut (
      .iCLK   (iCLK),
      .iRST_N (iRST_N),
      .bus    (bus.slave)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  blank;
      logic [55:0] seg;
   } vec_t;

   vec_t vecs[5];
   int   total = 0;
   int   passed = 0;

   localparam logic [55:0] ALL_ONES = {56{1'b1}};
   localparam logic [55:0] ALL_DARK = {8{7'h7F}};
   localparam logic [55:0] ALL_ZERO = {8{7'h40}};
   localparam logic [55:0] ALL_F    = {8{7'h0E}};
   localparam logic [55:0] SEG_0123 =
      {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
   localparam logic [55:0] SEG_ROT1 =
      {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h40};
   localparam logic [55:0] SEG_BLK1 =
      {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h7F};

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge iCLK);
      @(negedge iCLK);
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.oTICK && n < 20);
      if (!bus.oTICK) begin
         total++;
         $display("FAIL tick_timeout: no oTICK within %0d cycles", n);
      end
   endtask

   task automatic load(input logic [31:0] d);
      bus.iDATA = d;
      bus.iLOAD = 1'b1;
      step();
      bus.iLOAD = 1'b0;
   endtask

   initial begin
      int n;
      int ticks;

      vecs[0] = '{32'h01234567, 8'h00, SEG_0123};
      vecs[1] = '{32'h89ABCDEF, 8'h00,
         {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
      vecs[2] = '{32'h89ABCDEF, 8'hF0,
         {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h46, 7'h21, 7'h06, 7'h0E}};
      vecs[3] = '{32'h00000000, 8'h81,
         {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F}};
      vecs[4] = '{32'hFEDCBA98, 8'h00,
         {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}};

      bus.iLOAD  = 1'b0;
      bus.iDATA  = '0;
      bus.iMODE  = 2'b00;
      bus.iBLANK = '0;

      // Reset state and first prescaler periods
      @(negedge iCLK);
      @(negedge iCLK);
      check("rst_seg", 64'(bus.oSEG), 64'(ALL_ONES));
      check("rst_ack", 64'(bus.oACK), 64'd0);
      check("rst_tick", 64'(bus.oTICK), 64'd0);
      iRST_N = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (i == 1) check("first_seg", 64'(bus.oSEG), 64'(ALL_ZERO));
         check($sformatf("tick_c%0d", i), 64'(bus.oTICK),
               64'((i % 4) == 0));
      end

      // Static decode table
      for (int v = 0; v < 5; v++) begin
         bus.iBLANK = vecs[v].blank;
         load(vecs[v].data);
         check($sformatf("vec%0d_ack", v), 64'(bus.oACK), 64'd1);
         step();
         check($sformatf("vec%0d_ack0", v), 64'(bus.oACK), 64'd0);
         check($sformatf("vec%0d_seg", v), 64'(bus.oSEG),
               64'(vecs[v].seg));
      end

      // Static hold over 20 ticks; load restarts the prescaler
      bus.iBLANK = '0;
      load(32'h01234567);
      check("static_ack", 64'(bus.oACK), 64'd1);
      wait_tick(n);
      check("load_clr_psc", 64'(n), 64'd4);
      ticks = 0;
      for (int i = 0; i < 76; i++) begin
         step();
         if (bus.oTICK) ticks++;
      end
      check("static_ticks", 64'(ticks), 64'd19);
      check("static_seg", 64'(bus.oSEG), 64'(SEG_0123));

      // Scroll
      bus.iMODE = 2'b01;
      load(32'h01234567);
      wait_tick(n);
      step();
      check("scroll_1", 64'(bus.oSEG), 64'(SEG_ROT1));
      for (int j = 0; j < 7; j++) begin
         wait_tick(n);
      end
      step();
      check("scroll_8", 64'(bus.oSEG), 64'(SEG_0123));

      // Count with wrap
      bus.iMODE = 2'b11;
      load(32'hFFFFFFFE);
      wait_tick(n);
      step();
      check("count_1", 64'(bus.oSEG), 64'(ALL_F));
      wait_tick(n);
      step();
      check("count_wrap", 64'(bus.oSEG), 64'(ALL_ZERO));

      // Blink with digit 0 blanked
      bus.iMODE  = 2'b10;
      bus.iBLANK = 8'h01;
      load(32'h01234567);
      step();
      check("blink_on0", 64'(bus.oSEG), 64'(SEG_BLK1));
      wait_tick(n);
      step();
      check("blink_off", 64'(bus.oSEG), 64'(ALL_DARK));
      wait_tick(n);
      step();
      check("blink_on1", 64'(bus.oSEG), 64'(SEG_BLK1));
      step();
      step();
      check("blink_pre", 64'(bus.oSEG), 64'(SEG_BLK1));
      // This load lands on a tick edge with the phase ON
      load(32'h01234567);
      check("tickload_ack", 64'(bus.oACK), 64'd1);
      step();
      check("tickload_on", 64'(bus.oSEG), 64'(SEG_BLK1));
      wait_tick(n);
      check("tickload_psc", 64'(n), 64'd3);
      step();
      check("blink_off2", 64'(bus.oSEG), 64'(ALL_DARK));

      // Mode change forces the phase back ON
      bus.iMODE = 2'b00;
      step();
      bus.iMODE = 2'b10;
      step();
      check("modechg_on", 64'(bus.oSEG), 64'(SEG_BLK1));

      // Reset in mid-period scroll with a load pending
      bus.iBLANK = '0;
      bus.iMODE  = 2'b01;
      step();
      step();
      bus.iDATA = 32'h89ABCDEF;
      bus.iLOAD = 1'b1;
      #2;
      iRST_N = 1'b0;
      #1;
      check("arst_seg", 64'(bus.oSEG), 64'(ALL_ONES));
      check("arst_tick", 64'(bus.oTICK), 64'd0);
      @(posedge iCLK);
      #1;
      check("arst_ack", 64'(bus.oACK), 64'd0);
      bus.iLOAD = 1'b0;
      @(negedge iCLK);
      iRST_N = 1'b1;
      step();
      check("post_rst_seg", 64'(bus.oSEG), 64'(ALL_ZERO));
      check("post_rst_ack", 64'(bus.oACK), 64'd0);
      wait_tick(n);
      check("post_rst_tick", 64'(n), 64'd3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
